hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage pipeline (F, D, E, M, W).
- Detects load-use hazards that the stage-4/5 bypass cannot cover. Squashes wrong-path instructions on taken branches. Freezes the pipeline while data memory is not ready.
- A small FSM tracks memory-wait duration, raises a sticky timeout error and keeps saturating stall/flush event counters.
- Sits beside the bypass muxes; drives the enable/clear inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB registers.

---
 rtl/hazard_ctrl_pkg.sv | 12 +
 rtl/hazard_ctrl_sat_counter.sv | 31 +++
 rtl/hazard_ctrl.sv | 128 ++++++++++++
 tb/tb_hazard_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } hz_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (clr_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, taken-branch squash,
// data-memory wait with sticky timeout, plus saturating stall/flush event counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic             Rs1UsedD,
  input  logic             Rs2UsedD,
  input  logic [4:0]       RdE,
  input  logic             RDValidE,
  input  logic             MemReadE,
  input  logic             BranchTakenE,
  input  logic             MemReqM,
  input  logic             MemReady,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

  hz_state_e   state_q, state_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic        lu;
  logic        mw;

  assign mw = MemReqM & ~MemReady;
  assign lu = MemReadE & RDValidE & (RdE != REG_ZERO) &
              ((Rs1UsedD & (Rs1D == RdE)) | (Rs2UsedD & (Rs2D == RdE)));

  // Priority: frozen error > memory wait > taken branch > load-use.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if ((state_q == ERR) || mw) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (BranchTakenE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (lu) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      RUN: begin
        if (mw) begin
          state_d = WAIT;
          wcnt_d  = 16'd1;
        end else begin
          wcnt_d  = 16'd0;
        end
      end
      WAIT: begin
        if (!mw) begin
          state_d = RUN;
          wcnt_d  = 16'd0;
        end else if (wcnt_q == TIMEOUT_W) begin
          state_d = ERR;
        end else begin
          wcnt_d  = wcnt_q + 16'd1;
        end
      end
      ERR: begin
        state_d = ERR;
      end
      default: begin
        state_d = RUN;
        wcnt_d  = 16'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      wcnt_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // ERR is only ever entered together with the timeout, so the state doubles as the sticky flag.
  assign MemErr = (state_q == ERR);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr_i (rst),
    .inc_i (StallF),
    .cnt_o (StallCnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clr_i (rst),
    .inc_i (FlushD | FlushE),
    .cnt_o (FlushCnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with TIMEOUT=4 and 3-bit counters.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] Rs1D, Rs2D, RdE;
  logic       Rs1UsedD, Rs2UsedD, RDValidE, MemReadE, BranchTakenE, MemReqM, MemReady;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
  logic [2:0] StallCnt, FlushCnt;

  int errors = 0;
  int checks = 0;

  localparam logic [6:0] O_NONE = 7'b0000000;
  localparam logic [6:0] O_LU   = 7'b1100010;
  localparam logic [6:0] O_BR   = 7'b0000110;
  localparam logic [6:0] O_MW   = 7'b1111001;

  hazard_ctrl #(.TIMEOUT(4), .CNT_W(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .Rs1D         (Rs1D),
    .Rs2D         (Rs2D),
    .Rs1UsedD     (Rs1UsedD),
    .Rs2UsedD     (Rs2UsedD),
    .RdE          (RdE),
    .RDValidE     (RDValidE),
    .MemReadE     (MemReadE),
    .BranchTakenE (BranchTakenE),
    .MemReqM      (MemReqM),
    .MemReady     (MemReady),
    .StallF       (StallF),
    .StallD       (StallD),
    .StallE       (StallE),
    .StallM       (StallM),
    .FlushD       (FlushD),
    .FlushE       (FlushE),
    .FlushW       (FlushW),
    .MemErr       (MemErr),
    .StallCnt     (StallCnt),
    .FlushCnt     (FlushCnt)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] outs();
    return {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    Rs1D = 5'd0; Rs2D = 5'd0; RdE = 5'd0;
    Rs1UsedD = 1'b0; Rs2UsedD = 1'b0; RDValidE = 1'b0; MemReadE = 1'b0;
    BranchTakenE = 1'b0; MemReqM = 1'b0; MemReady = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_lu();
    MemReadE = 1'b1; RDValidE = 1'b1; RdE = 5'd5; Rs1D = 5'd5; Rs1UsedD = 1'b1;
  endtask

  initial begin
    clear_inputs();
    do_reset();
    #1;
    chk("rst_outs", 32'(outs()), 32'(O_NONE));
    chk("rst_memerr", 32'(MemErr), 32'd0);
    chk("rst_stallcnt", 32'(StallCnt), 32'd0);
    chk("rst_flushcnt", 32'(FlushCnt), 32'd0);

    // Load-use through rs1, then rs2, then guards
    set_lu();
    #1 chk("lu_rs1", 32'(outs()), 32'(O_LU));
    tick();
    chk("lu_stallcnt", 32'(StallCnt), 32'd1);
    chk("lu_flushcnt", 32'(FlushCnt), 32'd1);
    Rs1UsedD = 1'b0;
    #1 chk("lu_unused", 32'(outs()), 32'(O_NONE));
    Rs2D = 5'd5; Rs2UsedD = 1'b1;
    #1 chk("lu_rs2", 32'(outs()), 32'(O_LU));
    Rs2UsedD = 1'b0;
    tick();
    chk("idle_stallcnt", 32'(StallCnt), 32'd1);
    chk("idle_flushcnt", 32'(FlushCnt), 32'd1);
    RdE = 5'd0; Rs1D = 5'd0; Rs1UsedD = 1'b1;
    #1 chk("x0_guard", 32'(outs()), 32'(O_NONE));
    RdE = 5'd5; Rs1D = 5'd5; RDValidE = 1'b0;
    #1 chk("no_rdvalid", 32'(outs()), 32'(O_NONE));
    RDValidE = 1'b1;

    // Taken branch beats load-use
    BranchTakenE = 1'b1;
    #1 chk("br_over_lu", 32'(outs()), 32'(O_BR));
    tick();
    chk("br_stallcnt", 32'(StallCnt), 32'd1);
    chk("br_flushcnt", 32'(FlushCnt), 32'd2);

    // Memory wait masks both branch and load-use
    MemReqM = 1'b1; MemReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("memwait_outs", 32'(outs()), 32'(O_MW));
      tick();
    end
    MemReady = 1'b1;
    #1 chk("mw_release", 32'(outs()), 32'(O_BR));
    chk("mw_memerr", 32'(MemErr), 32'd0);
    chk("mw_stallcnt", 32'(StallCnt), 32'd4);
    chk("mw_flushcnt", 32'(FlushCnt), 32'd2);
    tick();
    BranchTakenE = 1'b0;
    #1 chk("lu_after_wait", 32'(outs()), 32'(O_LU));
    chk("post_flushcnt", 32'(FlushCnt), 32'd3);

    // Timeout: 4 not-ready cycles tolerated, 5th sets MemErr
    do_reset();
    MemReqM = 1'b1; MemReady = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      #1 chk("to_outs", 32'(outs()), 32'(O_MW));
      tick();
      chk("to_memerr", 32'(MemErr), (i == 5) ? 32'd1 : 32'd0);
    end
    MemReqM = 1'b0; MemReady = 1'b1;
    #1 chk("err_frozen", 32'(outs()), 32'(O_MW));
    tick();
    chk("err_sticky", 32'(MemErr), 32'd1);
    chk("err_stallcnt", 32'(StallCnt), 32'd6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("err_rst_memerr", 32'(MemErr), 32'd0);
    chk("err_rst_stallcnt", 32'(StallCnt), 32'd0);
    chk("err_rst_outs", 32'(outs()), 32'(O_NONE));
    MemReqM = 1'b1; MemReady = 1'b0;
    tick();
    MemReqM = 1'b0;
    tick();
    chk("rst_left_err", 32'(MemErr), 32'd0);

    // Saturation of 3-bit counters
    do_reset();
    set_lu();
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 3) chk("sat_mid", 32'(StallCnt), 32'd3);
      if (i == 7) chk("sat_top", 32'(StallCnt), 32'd7);
    end
    chk("sat_stallcnt", 32'(StallCnt), 32'd7);
    chk("sat_flushcnt", 32'(FlushCnt), 32'd7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
